// File: rtl/mem_resp.sv
// mem_resp: word-wide bus slave holding a synchronous RAM behind a programmable number of wait states.
// Every accepted access finishes with a one-cycle active-low ready strobe; a dropped request or reset cancels it.
module mem_resp #(
    parameter int ADDR_W = 11,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                rw_q, rw_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rdy_q, rdy_d;
    logic                rd_valid_q, rd_valid_d;

    logic [31:0]         ram [2**ADDR_W];
    logic [31:0]         rd_word_q;

    logic                req;
    logic                do_access;
    logic                acc_rw;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_data;
    logic                unused_addr;

    assign req         = ~cs_ & ~as_;
    assign unused_addr = ^addr[29:ADDR_W];

    // With no wait states the access happens at acceptance, so it uses the live bus instead of the latches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        do_access  = 1'b0;
        acc_idx    = idx_q;
        acc_rw     = rw_q;
        acc_data   = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = addr[ADDR_W-1:0];
                    rw_d    = rw;
                    wdata_d = wr_data;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT == 0) begin
                        do_access = 1'b1;
                        acc_idx   = addr[ADDR_W-1:0];
                        acc_rw    = rw;
                        acc_data  = wr_data;
                        state_d   = S_READY;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = S_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rdy_d      = ~do_access;
        rd_valid_d = do_access & acc_rw;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= 32'd0;
            rdy_q      <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            rdy_q      <= rdy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // The array is never reset; gating on reset_ keeps a held request from writing while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset_ && do_access) begin
            if (acc_rw) begin
                rd_word_q <= ram[acc_idx];
            end else begin
                ram[acc_idx] <= acc_data;
            end
        end
    end

    assign rd_data = rd_valid_q ? rd_word_q : 32'd0;
    assign rdy_    = rdy_q;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: four instances (WAIT = 0..3) share one bus and are each checked every cycle
// against a cycle-count/array model, with directed bus scenarios plus a randomized bus phase.
module tb_mem_resp;

    localparam int NI    = 4;
    localparam int AW    = 11;
    localparam int DEPTH = 2 ** AW;

    logic        clk     = 1'b0;
    logic        reset_  = 1'b0;
    logic        cs_     = 1'b0;
    logic        as_     = 1'b0;
    logic        rw      = 1'b1;
    logic [29:0] addr    = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rdData [NI];
    logic        rdyN   [NI];

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : gDut
            mem_resp #(.ADDR_W(AW), .WAIT(g)) dut (
                .clk     (clk),
                .reset_  (reset_),
                .cs_     (cs_),
                .as_     (as_),
                .rw      (rw),
                .addr    (addr),
                .wr_data (wr_data),
                .rd_data (rdData[g]),
                .rdy_    (rdyN[g])
            );
        end
    endgenerate

    // Reference: instance g completes a request after g further edges with the request held, then
    // shows one ready cycle; memM/memKnown are the per-instance RAM images.
    bit          busyM    [NI];
    int          remM     [NI];
    logic [AW-1:0] idxM   [NI];
    logic        rwM      [NI];
    logic [31:0] dataM    [NI];
    logic        expRdy   [NI];
    logic [31:0] expRd    [NI];
    bit          expKnown [NI];
    logic [31:0] memM     [NI][DEPTH];
    bit          memKnown [NI][DEPTH];
    logic        mReq;

    function automatic void performAccess(int g, logic [AW-1:0] idx, logic isRead, logic [31:0] d);
        expRdy[g] = 1'b0;
        if (isRead) begin
            expRd[g]    = memM[g][idx];
            expKnown[g] = memKnown[g][idx];
        end else begin
            memM[g][idx]     = d;
            memKnown[g][idx] = 1'b1;
            expRd[g]         = '0;
            expKnown[g]      = 1'b1;
        end
    endfunction

    task automatic modelStep();
        mReq = ~cs_ & ~as_;
        for (int g = 0; g < NI; g++) begin
            if (!reset_) begin
                busyM[g]    = 1'b0;
                expRdy[g]   = 1'b1;
                expRd[g]    = '0;
                expKnown[g] = 1'b1;
            end else if (!expRdy[g]) begin
                expRdy[g]   = 1'b1;
                expRd[g]    = '0;
                expKnown[g] = 1'b1;
                busyM[g]    = 1'b0;
            end else if (!busyM[g]) begin
                if (mReq) begin
                    idxM[g]  = addr[AW-1:0];
                    rwM[g]   = rw;
                    dataM[g] = wr_data;
                    if (g == 0) performAccess(g, addr[AW-1:0], rw, wr_data);
                    else begin
                        busyM[g] = 1'b1;
                        remM[g]  = g;
                    end
                end
            end else if (!mReq) begin
                busyM[g] = 1'b0;
            end else begin
                remM[g] = remM[g] - 1;
                if (remM[g] == 0) begin
                    busyM[g] = 1'b0;
                    performAccess(g, idxM[g], rwM[g], dataM[g]);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_);
        modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checkEn) begin
            for (int g = 0; g < NI; g++) begin
                checkOutput($sformatf("cycle rdy_[%0d]", g), 32'(rdyN[g]), 32'(expRdy[g]));
                if (expKnown[g]) checkOutput($sformatf("cycle rd_data[%0d]", g), rdData[g], expRd[g]);
            end
        end
    end

    // Drives one request (called at a negedge), holds it until instance g strobes ready, then idles the bus.
    task automatic applyStimulus(input logic isRead, input logic [29:0] a, input logic [31:0] d, input int g,
                                 output logic [31:0] got, output logic [31:0] gotNext, output int lat);
        cs_ = 1'b0; as_ = 1'b0; rw = isRead; addr = a; wr_data = d;
        lat = -1;
        got = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rdyN[g] == 1'b0) begin
                lat = n;
                got = rdData[g];
                break;
            end
        end
        as_ = 1'b1; cs_ = 1'b1;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready timeout rdy_[%0d] actual=no-strobe required=strobe", g);
        end
        @(negedge clk);
        gotNext = rdData[g];
        repeat (3) @(negedge clk);
    endtask

    logic [31:0]   got, gotNext;
    int            lat;
    logic [AW-1:0] rIdx [8];

    initial begin
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                checkOutput("reset rdy_", 32'(rdyN[g]), 32'd1);
                checkOutput("reset rd_data", rdData[g], 32'd0);
            end
        end
        reset_ = 1'b1;
        applyStimulus(1'b0, 30'h005, 32'hDEADBEEF, 1, got, gotNext, lat);
        checkOutput("wait1 write latency", 32'(lat), 32'd2);
        applyStimulus(1'b1, 30'h005, 32'h0, 1, got, gotNext, lat);
        checkOutput("wait1 read latency", 32'(lat), 32'd2);
        checkOutput("wait1 read data", got, 32'hDEADBEEF);
        checkOutput("wait1 data after ready", gotNext, 32'd0);

        applyStimulus(1'b0, 30'h010, 32'h1, 3, got, gotNext, lat);
        checkOutput("wait3 write latency", 32'(lat), 32'd4);
        applyStimulus(1'b0, 30'h011, 32'h2, 3, got, gotNext, lat);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 30'h010;
        @(negedge clk);
        checkOutput("b2b first rdy_", 32'(rdyN[0]), 32'd0);
        checkOutput("b2b first data", rdData[0], 32'h1);
        addr = 30'h011;
        @(negedge clk);
        checkOutput("b2b gap rdy_", 32'(rdyN[0]), 32'd1);
        @(negedge clk);
        checkOutput("b2b second rdy_", 32'(rdyN[0]), 32'd0);
        checkOutput("b2b second data", rdData[0], 32'h2);
        as_ = 1'b1; cs_ = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(1'b0, 30'h020, 32'hAAAA5555, 3, got, gotNext, lat);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'h020; wr_data = 32'h12345678;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort held rdy_", 32'(rdyN[3]), 32'd1);
        end
        as_ = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort dropped rdy_", 32'(rdyN[3]), 32'd1);
        end
        cs_ = 1'b1;
        applyStimulus(1'b1, 30'h020, 32'h0, 3, got, gotNext, lat);
        checkOutput("abort old data", got, 32'hAAAA5555);

        applyStimulus(1'b0, 30'h0800_0003, 32'hCAFEF00D, 1, got, gotNext, lat);
        applyStimulus(1'b1, 30'h003, 32'h0, 1, got, gotNext, lat);
        checkOutput("alias read data", got, 32'hCAFEF00D);
        cs_ = 1'b1; as_ = 1'b0; rw = 1'b1; addr = 30'h003;
        repeat (5) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                checkOutput("deselected rdy_", 32'(rdyN[g]), 32'd1);
                checkOutput("deselected rd_data", rdData[g], 32'd0);
            end
        end
        as_ = 1'b1;

        applyStimulus(1'b0, 30'h030, 32'h0BADF00D, 3, got, gotNext, lat);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'h030; wr_data = 32'h55555555;
        @(negedge clk);
        #1 reset_ = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            checkOutput("mid reset rdy_", 32'(rdyN[g]), 32'd1);
            checkOutput("mid reset rd_data", rdData[g], 32'd0);
        end
        as_ = 1'b1; cs_ = 1'b1;
        @(negedge clk);
        reset_ = 1'b1;
        applyStimulus(1'b1, 30'h030, 32'h0, 2, got, gotNext, lat);
        checkOutput("mid reset old data", got, 32'h0BADF00D);

        for (int k = 0; k < 8; k++) begin
            rIdx[k] = AW'(512 + k * 37);
            applyStimulus(1'b0, {19'd0, rIdx[k]}, $urandom, 3, got, gotNext, lat);
        end
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            reset_ = ($urandom_range(0, 299) != 0);
            cs_    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) as_ = ~as_;
            if ($urandom_range(0, 2) == 0) begin
                rw      = 1'($urandom_range(0, 1));
                addr    = {19'($urandom), rIdx[$urandom_range(0, 7)]};
                wr_data = $urandom;
            end
        end
        @(negedge clk);
        #1;
        reset_ = 1'b1; as_ = 1'b1; cs_ = 1'b1;
        repeat (6) @(negedge clk);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
